// File: rtl/stream_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : stream_pkg                                                    |
// | Description : Shared types and default widths for the stream blocks.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package stream_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int GAP_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } src_state_e;

  typedef logic [DATA_WIDTH_DEF-1:0] beat_t;

endpackage
`default_nettype wire

// File: rtl/stream_burst_source.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : stream_burst_source                                           |
// | Description : Burst traffic source: one command -> incrementing beats on a  |
// |               valid/ready port with optional idle gaps between beats.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module stream_burst_source
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int GAP_WIDTH  = GAP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_base,
  input  logic [CNT_WIDTH-1:0]  cmd_len,
  input  logic [GAP_WIDTH-1:0]  cmd_gap,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  src_state_e           r_state;
  logic [CNT_WIDTH-1:0] r_len;
  logic [GAP_WIDTH-1:0] r_gap;
  logic [GAP_WIDTH-1:0] r_gap_cnt;

  logic                 w_accept;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [CNT_WIDTH-1:0] w_len_m1;

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = out_valid & out_ready;
  assign w_cnt_inc = beat_count + CNT_WIDTH'(1);
  assign w_len_m1  = r_len - CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      beat_count <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            beat_count <= '0;
            if (cmd_len != '0) begin
              r_len     <= cmd_len;
              r_gap     <= cmd_gap;
              out_data  <= cmd_base;
              out_valid <= 1'b1;
              out_last  <= (cmd_len == CNT_WIDTH'(1));
              r_state   <= SEND;
            end else begin
              // Empty burst: consume the command and just signal completion.
              done <= 1'b1;
            end
          end
        end

        SEND: begin
          if (w_accept) begin
            beat_count <= w_cnt_inc;
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              r_state   <= IDLE;
            end else if (r_gap == '0) begin
              out_data <= out_data + DATA_WIDTH'(1);
              out_last <= (w_cnt_inc == w_len_m1);
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              r_gap_cnt <= r_gap;
              r_state   <= GAP;
            end
          end
        end

        GAP: begin
          // beat_count already reflects the accepted beat, so it indexes the next one.
          if (r_gap_cnt == GAP_WIDTH'(1)) begin
            out_valid <= 1'b1;
            out_data  <= out_data + DATA_WIDTH'(1);
            out_last  <= (beat_count == w_len_m1);
            r_state   <= SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
          end
        end

        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_burst_source.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_stream_burst_source                                        |
// | Description : Directed self-checking bench for stream_burst_source.         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_stream_burst_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_base;
  logic [15:0] cmd_len;
  logic [3:0]  cmd_gap;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] beat_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_burst_source dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_len    (cmd_len),
    .cmd_gap    (cmd_gap),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] base, input logic [15:0] len, input logic [3:0] gap);
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    cmd_gap   = gap;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] data, input logic last);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, data);
    chk({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; cmd_gap = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_cnt",   {16'd0, beat_count}, 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Single-beat burst
    out_ready = 1'b1;
    send_cmd(32'hA5A5A5A5, 16'd1, 4'd0);
    beat("t1", 32'hA5A5A5A5, 1'b1);
    chk("t1_cmdrdy_busy", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_valid_off", {31'd0, out_valid}, 32'd0);
    chk("t1_cnt", {16'd0, beat_count}, 32'd1);
    chk("t1_cmdrdy", {31'd0, cmd_ready}, 32'd1);
    step();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);

    // Backpressure holds the first beat for four cycles
    out_ready = 1'b0;
    send_cmd(32'h12345678, 16'd3, 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      beat("t2_hold", 32'h12345678, 1'b0);
      step();
    end
    beat("t2_b1", 32'h12345679, 1'b0);
    step();
    beat("t2_b2", 32'h1234567A, 1'b1);
    step();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_cnt", {16'd0, beat_count}, 32'd3);

    // Gap of two idle cycles between beats
    send_cmd(32'h10, 16'd3, 4'd2);
    beat("t3_b0", 32'h10, 1'b0);
    step();
    chk("t3_gap0a", {31'd0, out_valid}, 32'd0);
    step();
    chk("t3_gap0b", {31'd0, out_valid}, 32'd0);
    step();
    beat("t3_b1", 32'h11, 1'b0);
    step();
    chk("t3_gap1a", {31'd0, out_valid}, 32'd0);
    chk("t3_gap_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t3_gap1b", {31'd0, out_valid}, 32'd0);
    step();
    beat("t3_b2", 32'h12, 1'b1);
    step();
    chk("t3_done", {31'd0, done}, 32'd1);

    // Data wraps modulo 2^32
    send_cmd(32'hFFFFFFFE, 16'd3, 4'd0);
    beat("t4_b0", 32'hFFFFFFFE, 1'b0);
    step();
    beat("t4_b1", 32'hFFFFFFFF, 1'b0);
    step();
    beat("t4_b2", 32'h00000000, 1'b1);
    step();
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_cnt", {16'd0, beat_count}, 32'd3);

    // done cycle doubles as a command-accept cycle: empty burst accepted here
    send_cmd(32'h0, 16'd0, 4'd0);
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_cnt", {16'd0, beat_count}, 32'd0);
    step();
    chk("t5_done_pulse", {31'd0, done}, 32'd0);
    chk("t5_novalid", {31'd0, out_valid}, 32'd0);

    // Command while busy is ignored
    out_ready = 1'b0;
    send_cmd(32'h100, 16'd2, 4'd0);
    cmd_valid = 1'b1; cmd_base = 32'h999; cmd_len = 16'd1;
    chk("t6_cmdrdy", {31'd0, cmd_ready}, 32'd0);
    step();
    cmd_valid = 1'b0;
    beat("t6_b0", 32'h100, 1'b0);
    out_ready = 1'b1;
    step();
    beat("t6_b1", 32'h101, 1'b1);
    step();
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_cnt", {16'd0, beat_count}, 32'd2);
    step();
    chk("t6_no_extra", {31'd0, out_valid}, 32'd0);

    // Reset mid-burst aborts without done
    send_cmd(32'h200, 16'd5, 4'd0);
    step();
    beat("t7_b1", 32'h201, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_busy", {31'd0, busy}, 32'd0);
    chk("t7_done", {31'd0, done}, 32'd0);
    chk("t7_cnt", {16'd0, beat_count}, 32'd0);
    step();
    chk("t7_done_later", {31'd0, done}, 32'd0);
    send_cmd(32'h300, 16'd2, 4'd0);
    beat("t7_n0", 32'h300, 1'b0);
    step();
    beat("t7_n1", 32'h301, 1'b1);
    step();
    chk("t7_ndone", {31'd0, done}, 32'd1);
    chk("t7_ncnt", {16'd0, beat_count}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_burst_source.md
Name: stream_burst_source

Overview:
- Valid/ready transmitter that drives the input side of the stream pipeline register.
- Accepts one burst command carrying a base value, a beat count and an idle gap.
- Emits the incrementing data beats on a valid/ready master port and obeys backpressure.
- Used as the on-chip traffic source for pipeline stages and as a bring-up stimulus block.

Parameters:
DATA_WIDTH, 32, width of out_data and cmd_base
CNT_WIDTH, 16, width of cmd_len and beat_count
GAP_WIDTH, 4, width of cmd_gap (idle cycles inserted between beats)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  burst command valid
cmd_ready  output  1  block can accept a command
cmd_base  input  DATA_WIDTH  data value of the first beat
cmd_len  input  CNT_WIDTH  number of beats; 0 = empty burst
cmd_gap  input  GAP_WIDTH  idle cycles after each non-final beat
out_valid  output  1  stream beat valid
out_ready  input  1  downstream accepts beat
out_data  output  DATA_WIDTH  beat payload
out_last  output  1  marks the final beat of a burst
busy  output  1  burst in progress (state != IDLE)
done  output  1  one-cycle pulse when a burst completes
beat_count  output  CNT_WIDTH  beats accepted in the current or most recent burst

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, out_last=0, out_data=0, done=0, beat_count=0, busy=0.
- Reset mid-burst aborts the burst. No done pulse is produced. out_valid is 0 from the cycle after the reset edge.
- States: IDLE, SEND, GAP.
- cmd_ready = (state==IDLE). It is combinational from state only and never depends on cmd_valid.
- IDLE, cmd_valid & cmd_len!=0:
  - Latch base, len and gap; clear beat_count.
  - Go to SEND; out_valid=1 and out_data=cmd_base on the next cycle (latency 1).
- IDLE, cmd_valid & cmd_len==0:
  - Command is consumed and beat_count is cleared.
  - done pulses the next cycle; state stays IDLE; no beats are emitted.
- SEND: out_valid=1; out_data and out_last are held stable while out_ready=0 (no retraction, no change).
- SEND, beat accepted (out_valid & out_ready at the edge):
  - beat_count increments.
  - If the beat was last: go to IDLE, out_valid=0, done=1 for one cycle, cmd_ready=1 in that same cycle.
  - Else if latched gap==0: stay in SEND, out_data+1, back-to-back at one beat per cycle.
  - Else: go to GAP with out_valid=0 and gap counter = gap.
- GAP:
  - Counter decrements each cycle.
  - When it reaches 1, the next cycle is SEND with out_data = previous+1.
  - Exactly `gap` idle cycles occur between accepted beats.
- out_last = 1 while out_valid and beat_count == len-1.
- out_data increments modulo 2^DATA_WIDTH (0xFFFFFFFF -> 0x00000000, no error).
- beat_count saturates at neither end; len ≤ 2^CNT_WIDTH-1 by construction.
- out_ready while out_valid=0 has no effect.
- cmd_valid while busy is ignored; no command is consumed.
- done and the next command acceptance may occur in the same cycle (done cycle, cmd_valid=1): both happen.

Decomposition:
- stream_pkg holds:
  - src_state_e enum {IDLE, SEND, GAP}.
  - Default width localparams.
  - beat_t typedef (logic [DATA_WIDTH-1:0]) for shared stream blocks.
- No sub-module: FSM, beat counter and gap counter live in one module.
- The gap down-counter may be factored as stream_gap_timer if reused by the stream sink.

Test Plan:
- Reset, then cmd base=0xA5A5A5A5 len=1 gap=0, out_ready=1 -> one beat 0xA5A5A5A5 with out_last=1 at cmd+1, done pulse at cmd+2, beat_count=1.
- cmd base=0x12345678 len=3 gap=0, out_ready=0 for 3 cycles then 1 -> out_data held 0x12345678 for 4 cycles, then 0x12345679 and 0x1234567A back-to-back, out_last only on 0x1234567A.
- cmd base=0x10 len=3 gap=2, out_ready=1 -> beats 0x10, 0x11, 0x12 each separated by exactly 2 cycles of out_valid=0, done after 0x12.
- cmd base=0xFFFFFFFE len=3 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; beat_count=3.
- cmd len=0 -> no out_valid, done pulse next cycle; cmd_valid pulsed during a busy burst -> ignored, cmd_ready=0.
- rst asserted while out_valid=1 in the middle of a len=5 burst -> out_valid=0, busy=0, no done; next command runs normally from its base.
